// File: rtl/shift_rows_stream.sv
// Byte-serial AES/Rijndael ShiftRows / InvShiftRows engine with ping-pong block buffers.
// One element per cycle in and out; direction is latched per block from the first element.
module shift_rows_stream #(
  parameter int DATA_W = 8,
  parameter int NB     = 4,
  parameter int SHIFT1 = 1,
  parameter int SHIFT2 = 2,
  parameter int SHIFT3 = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inverse,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int L     = 4 * NB;
  localparam int IDX_W = $clog2(L);
  localparam int CW    = IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);
  localparam logic [CW:0]      NB_W     = (CW + 1)'(NB);

  if (!(NB == 4 || NB == 6 || NB == 8) ||
      SHIFT1 < 0 || SHIFT1 >= NB ||
      SHIFT2 < 0 || SHIFT2 >= NB ||
      SHIFT3 < 0 || SHIFT3 >= NB) begin : g_param_check
    $error("shift_rows_stream: NB must be 4, 6 or 8 and every row shift must be < NB");
  end

  logic [DATA_W-1:0] mem_q [2][L];
  logic [1:0]        full_q, full_d;
  logic [1:0]        mode_q, mode_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;

  logic              wr_fire, rd_fire;
  logic [CW-1:0]     rd_col;
  logic [1:0]        rd_row;
  logic [CW:0]       row_shift;
  logic [CW:0]       col_sum;
  logic [IDX_W-1:0]  src_idx;

  // Source element for the current output slot: rotate the row by its offset,
  // left for forward, right for inverse, wrapping modulo NB.
  always_comb begin
    rd_col = rd_idx_q[IDX_W-1:2];
    rd_row = rd_idx_q[1:0];
    case (rd_row)
      2'd1:    row_shift = (CW + 1)'(SHIFT1);
      2'd2:    row_shift = (CW + 1)'(SHIFT2);
      2'd3:    row_shift = (CW + 1)'(SHIFT3);
      default: row_shift = '0;
    endcase
    if (mode_q[rd_bank_q]) col_sum = {1'b0, rd_col} + NB_W - row_shift;
    else                   col_sum = {1'b0, rd_col} + row_shift;
    if (col_sum >= NB_W) col_sum = col_sum - NB_W;
    src_idx = {col_sum[CW-1:0], rd_row};
  end

  assign in_ready  = !reset && !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign out_data  = out_valid ? mem_q[rd_bank_q][src_idx] : '0;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  // A filling bank and a draining bank are always different, so their full bits never collide.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;

    if (wr_fire) begin
      if (wr_idx_q == '0) mode_d[wr_bank_q] = inverse;
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_idx_d          = '0;
        rd_bank_d         = !rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q    <= '0;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // NOTE: the data banks are not reset; a bank is only read after its full flag
  // is set, which implies every element of it was written first.
  always_ff @(posedge clock) begin
    if (wr_fire) mem_q[wr_bank_q][wr_idx_q] <= in_data;
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream: NB=4 (shifts 1/2/3) and NB=8 (shifts 1/3/4)
// instances, checked against a row-rotation reference model and fixed AES vectors.
module tb_shift_rows_stream;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0][7:0] in_data   = '0;
  logic [1:0]      in_valid  = '0;
  logic [1:0]      inverse   = '0;
  logic [1:0]      out_ready = '0;
  wire  [1:0][7:0] out_data;
  wire  [1:0]      in_ready;
  wire  [1:0]      out_valid;
  wire  [1:0]      out_last;

  always #5 clock = ~clock;

  shift_rows_stream #(.DATA_W(8), .NB(4), .SHIFT1(1), .SHIFT2(2), .SHIFT3(3)) u_dut4 (
    .clock(clock), .reset(reset),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .inverse(inverse[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0])
  );

  shift_rows_stream #(.DATA_W(8), .NB(8), .SHIFT1(1), .SHIFT2(3), .SHIFT3(4)) u_dut8 (
    .clock(clock), .reset(reset),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .inverse(inverse[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1])
  );

  localparam logic [7:0] FWD4 [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                       8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  localparam logic [7:0] INV4 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                       8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

  int checks = 0;
  int errors = 0;

  logic [7:0] in_q  [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit         mode_q [$];

  int stat_stall, stat_first_out, stat_last_out, stat_last_in;
  int stat_inpos_hold, stat_rdy_hold;
  logic [7:0] stat_data_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: view the block as 4 rows of nb columns and rotate each row.
  task automatic add_block(input int sel, input bit inv, input logic [7:0] blk [$]);
    int nb;
    int sh [4];
    logic [7:0] res [32];
    nb    = (sel == 1) ? 8 : 4;
    sh[0] = 0;
    sh[1] = 1;
    sh[2] = (sel == 1) ? 3 : 2;
    sh[3] = (sel == 1) ? 4 : 3;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        int src_c;
        src_c = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        res[4*c+r] = blk[4*src_c+r];
      end
    end
    for (int k = 0; k < 4*nb; k++) begin
      in_q.push_back(blk[k]);
      exp_q.push_back(res[k]);
    end
    mode_q.push_back(inv);
  endtask

  task automatic add_random_block(input int sel, input bit inv);
    logic [7:0] blk [$];
    for (int k = 0; k < ((sel == 1) ? 32 : 16); k++) blk.push_back(8'($urandom));
    add_block(sel, inv, blk);
  endtask

  task automatic add_counting_block(input bit inv, input int base);
    logic [7:0] blk [$];
    for (int k = 0; k < 16; k++) blk.push_back(8'(base + k));
    add_block(0, inv, blk);
  endtask

  // Stream in_q into one DUT and check every accepted output against exp_q.
  // out_ready is held low for the first `hold` cycles, then high with probability ordy_pct.
  task automatic run(input int sel, input int ordy_pct, input int hold, input int budget);
    int blk_len, in_pos, out_pos, cyc;
    bit iv, ordy;
    blk_len = (sel == 1) ? 32 : 16;
    in_pos = 0; out_pos = 0; cyc = 0;
    stat_stall = 0; stat_first_out = -1; stat_last_out = -1; stat_last_in = -1;
    stat_inpos_hold = -1; stat_rdy_hold = -1; stat_data_hold = 8'hxx;
    got_q.delete();
    while (out_pos < exp_q.size() && cyc < budget) begin
      @(negedge clock);
      iv   = in_pos < in_q.size();
      ordy = (cyc >= hold) && ($urandom_range(99) < ordy_pct);
      in_valid[sel]  = iv;
      in_data[sel]   = iv ? in_q[in_pos] : 8'h00;
      inverse[sel]   = (iv && (in_pos % blk_len) == 0) ? mode_q[in_pos / blk_len] : 1'($urandom);
      out_ready[sel] = ordy;
      #1;
      if (cyc == hold - 1) begin
        stat_inpos_hold = in_pos;
        stat_rdy_hold   = int'(in_ready[sel]);
        stat_data_hold  = out_data[sel];
      end
      if (iv && !in_ready[sel]) stat_stall++;
      if (out_valid[sel] && stat_first_out < 0) stat_first_out = cyc;
      if (out_valid[sel] && ordy) begin
        check("out_data", out_data[sel], exp_q[out_pos]);
        check("out_last", out_last[sel], ((out_pos % blk_len) == blk_len - 1) ? 1 : 0);
        got_q.push_back(out_data[sel]);
        stat_last_out = cyc;
        out_pos++;
      end
      if (iv && in_ready[sel]) begin
        in_pos++;
        if (in_pos == blk_len) stat_last_in = cyc;
      end
      cyc++;
    end
    check("run_outputs_done", out_pos, exp_q.size());
    check("run_inputs_done", in_pos, in_q.size());
    @(negedge clock);
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b0;
    in_q.delete();
    exp_q.delete();
    mode_q.delete();
  endtask

  initial begin
    logic [7:0] orig [$];
    logic [7:0] fwd  [$];

    // Reset state on both instances
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      check("rst_out_valid", out_valid[s], 0);
      check("rst_out_last", out_last[s], 0);
      check("rst_out_data", out_data[s], 0);
      check("rst_in_ready", in_ready[s], 0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_in_ready4", in_ready[0], 1);
    check("post_rst_in_ready8", in_ready[1], 1);

    // Forward directed vector, including first-output latency
    for (int k = 0; k < 16; k++) begin
      in_q.push_back(8'(k));
      exp_q.push_back(FWD4[k]);
    end
    mode_q.push_back(1'b0);
    run(0, 100, 0, 100);
    check("fwd_latency", stat_first_out, stat_last_in + 1);

    // Inverse directed vector
    for (int k = 0; k < 16; k++) begin
      in_q.push_back(8'(k));
      exp_q.push_back(INV4[k]);
    end
    mode_q.push_back(1'b1);
    run(0, 100, 0, 100);

    // Three back-to-back blocks, modes 0/1/0, inverse randomised off k=0
    add_random_block(0, 1'b0);
    add_random_block(0, 1'b1);
    add_random_block(0, 1'b0);
    run(0, 100, 0, 200);
    check("stream_no_stall", stat_stall, 0);
    check("stream_contiguous", stat_last_out - stat_first_out + 1, 48);

    // Backpressure: out_ready low until both banks fill, then release
    add_counting_block(1'b0, 8'h00);
    add_counting_block(1'b0, 8'h10);
    add_counting_block(1'b0, 8'h20);
    run(0, 100, 45, 300);
    check("bp_accepted_at_hold", stat_inpos_hold, 32);
    check("bp_in_ready_low", stat_rdy_hold, 0);
    check("bp_out_data_held", stat_data_hold, 8'h00);
    check("bp_stalled", (stat_stall > 0) ? 1 : 0, 1);

    // Reset after 7 elements of a block
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(8'hA0 + k);
      inverse[0]  = 1'b0;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_in_ready", in_ready[0], 0);
    check("midrst_out_data", out_data[0], 0);
    @(negedge clock);
    reset       = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    check("midrst_in_ready_after", in_ready[0], 1);
    check("midrst_out_valid_after", out_valid[0], 0);
    for (int k = 0; k < 16; k++) begin
      in_q.push_back(8'(k));
      exp_q.push_back(FWD4[k]);
    end
    mode_q.push_back(1'b0);
    run(0, 100, 0, 100);

    // NB=4 random blocks and random output stalls
    for (int b = 0; b < 50; b++) add_random_block(0, 1'($urandom));
    run(0, 60, 0, 5000);

    // NB=8 round trip: forward, then inverse of the result
    for (int k = 0; k < 32; k++) orig.push_back(8'($urandom));
    add_block(1, 1'b0, orig);
    run(1, 100, 0, 200);
    fwd = got_q;
    add_block(1, 1'b1, fwd);
    run(1, 100, 0, 200);
    check("rt_length", got_q.size(), 32);
    for (int k = 0; k < 32 && k < got_q.size(); k++) check("rt_byte", got_q[k], orig[k]);

    // NB=8: 1000 random blocks, random modes, random output stalls
    for (int b = 0; b < 1000; b++) add_random_block(1, 1'($urandom));
    run(1, 75, 0, 60000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
